// File: rtl/delta_ctrl_pkg.sv
// Shared types and constants for the MFCC delta sequencer.
// Step order, op encodings and frame offsets of the five-step delta recipe.
package delta_pkg;

    localparam int NSTEP    = 5;
    localparam int NCEP_DEF = 13;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } step_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    typedef struct packed {
        logic en;
        logic ld;
        logic sub;
        logic shift;
    } op_t;

    localparam op_t OP_NEW       = 4'b1100;
    localparam op_t OP_SUB       = 4'b1010;
    localparam op_t OP_SHIFT_ADD = 4'b1001;
    localparam op_t OP_IDLE      = 4'b0000;

    localparam int OFF_S0 = 2;
    localparam int OFF_S1 = -2;
    localparam int OFF_S2 = 1;
    localparam int OFF_S3 = -1;
    localparam int OFF_S4 = -1;

    function automatic step_e next_step(input step_e s);
        if (s == step_e'(NSTEP - 1)) begin
            return S0;
        end
        return step_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/delta_ctrl_if.sv
// Handshake and datapath-control bundle of the delta sequencer.
// DELTA_CTRL_ABORT_EN adds the abort / aborted pair.
interface delta_if #(
    parameter int FRAME_AW = 3,
    parameter int COEF_AW  = 4
);

    logic                start;
    logic [FRAME_AW-1:0] center_slot;
    logic                busy;
    logic                done;
    logic                regc_rd;
    logic [FRAME_AW-1:0] regc_frame;
    logic [COEF_AW-1:0]  regc_coef;
    logic                delta_en;
    logic                delta_new;
    logic                delta_sub;
    logic                delta_shift;
    logic                dout_we;
    logic [COEF_AW-1:0]  dout_idx;
`ifdef DELTA_CTRL_ABORT_EN
    logic                abort;
    logic                aborted;

    modport master (
        input  start, center_slot, abort,
        output busy, done, regc_rd, regc_frame, regc_coef,
        output delta_en, delta_new, delta_sub, delta_shift,
        output dout_we, dout_idx, aborted
    );

    modport slave (
        output start, center_slot, abort,
        input  busy, done, regc_rd, regc_frame, regc_coef,
        input  delta_en, delta_new, delta_sub, delta_shift,
        input  dout_we, dout_idx, aborted
    );
`else
    modport master (
        input  start, center_slot,
        output busy, done, regc_rd, regc_frame, regc_coef,
        output delta_en, delta_new, delta_sub, delta_shift,
        output dout_we, dout_idx
    );

    modport slave (
        output start, center_slot,
        input  busy, done, regc_rd, regc_frame, regc_coef,
        input  delta_en, delta_new, delta_sub, delta_shift,
        input  dout_we, dout_idx
    );
`endif

endinterface

// File: rtl/delta_ctrl_step_rom.sv
// Step decoder: frame offset relative to the centre slot and accumulator op.
// Offsets wrap naturally through truncation to FRAME_AW bits.
module delta_step_rom
    import delta_pkg::*;
#(
    parameter int FRAME_AW = 3
) (
    input  step_e               step,
    output logic [FRAME_AW-1:0] offset,
    output op_t                 op
);

    always_comb begin
        offset = '0;
        op     = OP_IDLE;
        unique case (step)
            S0: begin
                offset = FRAME_AW'(OFF_S0);
                op     = OP_NEW;
            end
            S1: begin
                offset = FRAME_AW'(OFF_S1);
                op     = OP_SUB;
            end
            S2: begin
                offset = FRAME_AW'(OFF_S2);
                op     = OP_SHIFT_ADD;
            end
            S3: begin
                offset = FRAME_AW'(OFF_S3);
                op     = OP_SUB;
            end
            S4: begin
                offset = FRAME_AW'(OFF_S4);
                op     = OP_SUB;
            end
            default: begin
                offset = '0;
                op     = OP_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/delta_ctrl.sv
// MFCC delta sequencer: ring reads, accumulator controls, result write strobes.
// Optional abort path enabled with DELTA_CTRL_ABORT_EN.
module delta_ctrl
    import delta_pkg::*;
#(
    parameter int NCEP     = NCEP_DEF,
    parameter int FRAME_AW = 3,
    parameter int COEF_AW  = 4
) (
    input  logic     clk,
    input  logic     rst,
    delta_if.master  bus
);

    localparam logic [COEF_AW-1:0] LAST_K = COEF_AW'(NCEP - 1);

    state_e              state_q, state_d;
    step_e               step_q, step_d;
    logic [COEF_AW-1:0]  coef_q, coef_d;
    logic [FRAME_AW-1:0] center_q, center_d;

    logic [FRAME_AW-1:0] rom_off;
    op_t                 rom_op;
    logic                rd;
    logic                last_rd;
    logic                abort_hit;

    op_t                 p1_op;
    logic                p1_s4;
    logic [COEF_AW-1:0]  p1_idx;
    logic                we_q;
    logic [COEF_AW-1:0]  idx_q;
    logic                done_q;

    delta_step_rom #(
        .FRAME_AW (FRAME_AW)
    ) u_rom (
        .step   (step_q),
        .offset (rom_off),
        .op     (rom_op)
    );

    assign rd      = (state_q == RUN);
    assign last_rd = rd && (step_q == S4) && (coef_q == LAST_K);

    // The final write cannot be aborted; done wins over abort.
`ifdef DELTA_CTRL_ABORT_EN
    assign abort_hit = bus.abort && (state_q != IDLE) && !done_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        coef_d   = coef_q;
        center_d = center_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    step_d   = S0;
                    coef_d   = '0;
                    center_d = bus.center_slot;
                end
            end
            RUN: begin
                step_d = next_step(step_q);
                if (step_q == S4) begin
                    coef_d = coef_q + COEF_AW'(1);
                end
                if (last_rd) begin
                    state_d = FLUSH;
                    coef_d  = '0;
                end
            end
            FLUSH: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = IDLE;
            step_d  = S0;
            coef_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= S0;
            coef_q   <= '0;
            center_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            coef_q   <= coef_d;
            center_q <= center_d;
        end
    end

    // Stage 1 aligns ops with read data; stage 2 waits on the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_op  <= OP_IDLE;
            p1_s4  <= 1'b0;
            p1_idx <= '0;
            we_q   <= 1'b0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            p1_op  <= (rd && !abort_hit) ? rom_op : OP_IDLE;
            p1_s4  <= rd && !abort_hit && (step_q == S4);
            p1_idx <= coef_q;
            we_q   <= p1_s4 && !abort_hit;
            idx_q  <= (p1_s4 && !abort_hit) ? p1_idx : '0;
            done_q <= p1_s4 && !abort_hit && (p1_idx == LAST_K);
        end
    end

`ifdef DELTA_CTRL_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign bus.aborted = aborted_q;
`endif

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.regc_rd     = rd;
    assign bus.regc_frame  = rd ? (center_q + rom_off) : '0;
    assign bus.regc_coef   = rd ? coef_q : '0;
    assign bus.delta_en    = p1_op.en;
    assign bus.delta_new   = p1_op.ld;
    assign bus.delta_sub   = p1_op.sub;
    assign bus.delta_shift = p1_op.shift;
    assign bus.dout_we     = we_q;
    assign bus.dout_idx    = idx_q;

endmodule

// File: tb/tb_delta_ctrl.sv
// Randomised bench for delta_ctrl against a cycle-offset model of the schedule.
// Abort scenarios run only when DELTA_CTRL_ABORT_EN is defined.
module tb_delta_ctrl;

    localparam int N    = 13;
    localparam int LAST = 5 * N + 2;

    localparam int         OFFS [5] = '{2, -2, 1, -1, -1};
    localparam logic [3:0] OPS  [5] = '{4'b1100, 4'b1010, 4'b1001,
                                        4'b1010, 4'b1010};
    localparam int         WRAP [5] = '{2, 6, 1, 7, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;

    delta_if #(.FRAME_AW(3), .COEF_AW(4)) bus ();

    delta_ctrl #(
        .NCEP     (N),
        .FRAME_AW (3),
        .COEF_AW  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a run is fully described by its accept cycle and centre slot.
    logic       act = 1'b0;
    int         t0  = 0;
    logic [2:0] mc  = '0;
`ifdef DELTA_CTRL_ABORT_EN
    int         ab_at = -1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act <= 1'b0;
`ifdef DELTA_CTRL_ABORT_EN
            ab_at <= -1;
`endif
        end else begin
`ifdef DELTA_CTRL_ABORT_EN
            if (bus.abort && act && (cyc - t0) < LAST) begin
                act   <= 1'b0;
                ab_at <= cyc + 1;
            end else
`endif
            if (bus.start && !(act && (cyc - t0) <= LAST)) begin
                act <= 1'b1;
                t0  <= cyc;
                mc  <= bus.center_slot;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    logic       e_rd, e_we, e_done, e_busy;
    logic [2:0] e_frame;
    logic [3:0] e_coef, e_idx, e_ctrl;
    int         n, s, wcnt;

    always begin
        @(negedge clk or posedge rst);
        #1;
        e_rd = 0; e_we = 0; e_done = 0; e_busy = 0;
        e_frame = 0; e_coef = 0; e_idx = 0; e_ctrl = 0;
        n = 0;
        if (!rst && act) begin
            n = cyc - t0;
            if (n >= 1 && n <= 5 * N) begin
                s       = (n - 1) % 5;
                e_rd    = 1'b1;
                e_frame = 3'((int'(mc) + OFFS[s] + 8) % 8);
                e_coef  = 4'((n - 1) / 5);
            end
            if (n >= 2 && n <= 5 * N + 1) e_ctrl = OPS[(n - 2) % 5];
            if (n >= 7 && n <= LAST && (n - 7) % 5 == 0) begin
                e_we  = 1'b1;
                e_idx = 4'((n - 7) / 5);
            end
            e_done = (n == LAST);
            e_busy = (n >= 1 && n <= LAST);
        end
        check("rd_addr", {bus.regc_rd, bus.regc_frame, bus.regc_coef},
              {e_rd, e_frame, e_coef});
        check("ctrl", {bus.delta_en, bus.delta_new, bus.delta_sub,
                       bus.delta_shift}, e_ctrl);
        check("write", {bus.dout_we, bus.dout_idx, bus.done},
              {e_we, e_idx, e_done});
`ifdef DELTA_CTRL_ABORT_EN
        check("busy_abort", {bus.busy, bus.aborted},
              {e_busy, 1'(!rst && cyc == ab_at)});
`else
        check("busy", bus.busy, e_busy);
`endif
        if (rst || (act && n == 1)) wcnt = 0;
        if (!rst && act && mc == 3'd0 && n >= 1 && n <= 5)
            check("wrap_slot", bus.regc_frame, WRAP[n - 1]);
        if (!rst && bus.dout_we) begin
            check("idx_order", bus.dout_idx, wcnt);
            wcnt++;
        end
        if (!rst && act && bus.done) begin
            check("done_at", n, 32'd67);
            check("we_count", wcnt, 32'd13);
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [2:0] c, input int inj_start,
                       input int inj_rst, input int inj_abort);
        bus.start       = 1'b1;
        bus.center_slot = c;
        @(posedge clk);
        #1;
        for (int i = 1; i <= LAST; i++) begin
            bus.start       = (i == inj_start);
            bus.center_slot = 3'($urandom);
`ifdef DELTA_CTRL_ABORT_EN
            bus.abort       = (i == inj_abort);
`endif
            if (i == inj_rst) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                bus.start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
`ifdef DELTA_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.center_slot = '0;
`ifdef DELTA_CTRL_ABORT_EN
        bus.abort       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        run(3'd4, 10, 0, 0);
        run(3'd0, 0, 0, 0);
        idle(1);
        run(3'd5, 0, 30, 0);
        run(3'd7, 0, 0, 0);
`ifdef DELTA_CTRL_ABORT_EN
        run(3'd2, 0, 0, 20);
        run(3'd1, 0, 0, 66);
        run(3'd3, 0, 0, 67);
        idle(2);
`endif
        for (int r = 0; r < 8; r++) begin
            idle($urandom_range(0, 3));
            run(3'($urandom), $urandom_range(2, 67), 0, 0);
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
